seq_pattern_gen: RTL
====================

# seq_pattern_gen

Bit-serial pattern transmitter that drives `101` and `0110` sequences onto a single-bit line. It is the source end of the two-sequence detector path (`fsm_101_0110`). A requester hands over a pattern select and a repetition count through a valid/ready handshake. The block then serializes the pattern MSB-first, repeated back-to-back or with idle guard gaps, and signals `last` and `done`.

## Interface
Parameters:
- `CNT_W`, 4: width of the repetition count.
- `GAP_LEN`, 2: number of idle bit-times between repetitions. Must be ≥1. Used only when the gap feature is compiled in.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request; high only in IDLE.
- `req_sel`  in  1  0 = `101` (length 3), 1 = `0110` (length 4).
- `req_count`  in  CNT_W  number of repetitions; 0 is legal.
- `dout`  out  1  serial data bit, MSB of the pattern first.
- `dout_valid`  out  1  `dout` carries a pattern bit this cycle.
- `last`  out  1  final bit of the final repetition.
- `done`  out  1  one-cycle pulse after the final bit, or after acceptance when count = 0.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States:
  - IDLE → SEND on accept with count ≥ 1.
  - IDLE → DONE on accept with count = 0.
  - SEND → GAP after the last bit of a repetition when repetitions remain and the gap feature is enabled.
  - SEND → SEND (bit index wraps to 0) when repetitions remain and the gap feature is disabled.
  - SEND → DONE after the final bit.
  - GAP → SEND after GAP_LEN cycles.
  - DONE → IDLE unconditionally.
- Accept occurs at the edge where `req_valid && req_ready`. `req_sel` and `req_count` are latched at that edge. Inputs are ignored in all other states.
- Counters:
  - Bit index: 2 bits, counts 0..L-1.
  - Repetitions remaining: CNT_W bits, loaded with `req_count` and decremented at the end of each repetition.
  - Gap counter: $clog2(GAP_LEN+1) bits.
- `req_count` = 2^CNT_W−1 is legal. No wrap or overflow; the count saturates conceptually because it only decrements.
- Output values:
  - `dout` = 0 whenever `dout_valid` = 0, including IDLE, GAP and DONE.
  - `last` is asserted only together with `dout_valid`.
- Reset mid-operation: the next state is IDLE and all outputs return to reset values. The in-flight request is discarded with no `done`.

## Timing
- Reset values, visible the cycle after `reset` is sampled high: `dout`=0, `dout_valid`=0, `last`=0, `done`=0, `busy`=0, `req_ready`=1.
- `dout`, `dout_valid`, `last` and `done` are registered. `req_ready` and `busy` decode the state register.
- The first bit appears in the cycle after the accept edge.
- Latency from accept to `done` pulse = count·L + (count−1)·GAP_LEN·gap_en + 1 cycles. For count = 0, `done` follows 1 cycle after accept.
- `req_ready` is low from the cycle after accept through the DONE cycle. It returns high the cycle after `done`.
- A request held during busy is accepted in the first IDLE cycle.

## Configuration
- `SEQ_GEN_GAP_EN` defined: GAP state present. Between consecutive repetitions there are GAP_LEN cycles of `dout_valid`=0, `dout`=0. There is no gap after the final repetition.
- `SEQ_GEN_GAP_EN` undefined: GAP state and gap counter are not built. Repetitions are contiguous, and `dout_valid` stays high for count·L cycles.

## Structure
- Package `seq_gen_pkg` holds:
  - state enum: IDLE, SEND, GAP, DONE.
  - `PAT_101`=3'b101, `PAT_0110`=4'b0110.
  - length constants 3 and 4.
  - select encodings `SEL_101`=0, `SEL_0110`=1.
- One sub-module, `seq_pattern_rom`: combinational lookup from (sel, bit index) to bit value and last-bit-of-pattern flag.
- FSM and counters live in the top module.

## Test plan
- Reset, then sel=0, count=1 → `dout` = 1,0,1 on 3 consecutive valid cycles; `last` on the 3rd; `done` on the 4th; `req_ready` low for 4 cycles.
- sel=1, count=2, gap off → `dout` = 0,1,1,0,0,1,1,0 on 8 contiguous valid cycles; `last` only on the 8th; `done` on cycle 9.
- `SEQ_GEN_GAP_EN`, GAP_LEN=2, sel=0, count=2 → `dout` = 1,0,1, then 2 cycles with `dout_valid`=0, then 1,0,1; `done` at cycle 9 after accept.
- count=0 → no `dout_valid` cycles; `done` 1 cycle after accept; `req_ready` high again the cycle after that.
- `reset` asserted during the 2nd bit → next cycle `dout_valid`=0 and `busy`=0, with no `done`. A request issued after reset release behaves as in the first scenario. `req_valid` toggled while busy has no effect.
- Loopback into `fsm_101_0110`: sel=1, count=3, gap off → the detector `y` asserts exactly 3 times and reports no `101` hit.

Source files
------------

// File: rtl/seq_gen_pkg.sv
// seq_gen_pkg: shared states, pattern constants and select encodings for seq_pattern_gen.
package seq_gen_pkg;

  localparam int unsigned IDX_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [2:0] PAT_101  = 3'b101;
  localparam logic [3:0] PAT_0110 = 4'b0110;

  localparam int unsigned LEN_101  = 3;
  localparam int unsigned LEN_0110 = 4;

  localparam logic SEL_101  = 1'b0;
  localparam logic SEL_0110 = 1'b1;

endpackage

// File: rtl/seq_pattern_rom.sv
// seq_pattern_rom: combinational (sel, bit index) -> pattern bit and end-of-pattern flag.
module seq_pattern_rom
  import seq_gen_pkg::*;
(
  input  logic             i_sel,
  input  logic [IDX_W-1:0] i_idx,
  output logic             o_bit_c,
  output logic             o_last_c
);

  // Patterns left-aligned in a 4-bit word so index 0 always reads bit 3 (MSB first).
  logic [3:0]       w_pat;
  logic [IDX_W-1:0] w_last_idx;

  // Select the pattern word and its final index.
  always_comb begin
    w_pat      = {PAT_101, 1'b0};
    w_last_idx = IDX_W'(LEN_101 - 1);
    if (i_sel == SEL_0110) begin
      w_pat      = PAT_0110;
      w_last_idx = IDX_W'(LEN_0110 - 1);
    end
  end

  // Look up the addressed bit and flag the final bit of the pattern.
  always_comb begin
    o_bit_c  = w_pat[IDX_W'(3) - i_idx];
    o_last_c = (i_idx == w_last_idx);
  end

endmodule

// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: bit-serial 101 / 0110 transmitter with valid/ready request and repetition count.
// Build option: SEQ_GEN_GAP_EN inserts GAP_LEN idle bit-times between consecutive repetitions.
module seq_pattern_gen
  import seq_gen_pkg::*;
#(
  parameter int unsigned CNT_W   = 4,
  parameter int unsigned GAP_LEN = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_sel,
  input  logic [CNT_W-1:0] req_count,
  output logic             dout,
  output logic             dout_valid,
  output logic             last,
  output logic             done,
  output logic             busy
);

  if (GAP_LEN == 0) begin : g_gap_len_check
    $error("seq_pattern_gen: GAP_LEN must be at least 1");
  end

`ifdef SEQ_GEN_GAP_EN
  localparam int unsigned GAP_W = $clog2(GAP_LEN + 1);
  logic [GAP_W-1:0] r_gap;
  logic [GAP_W-1:0] w_gap_nxt;
`endif

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_sel;
  logic             w_sel_nxt;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx_nxt;
  logic [CNT_W-1:0] r_rep;
  logic [CNT_W-1:0] w_rep_nxt;
  logic             r_pat_end;

  logic             r_dout;
  logic             r_dout_valid;
  logic             r_last;
  logic             r_done;
  logic             w_dout_nxt;
  logic             w_dout_valid_nxt;
  logic             w_last_nxt;
  logic             w_done_nxt;

  logic             w_rom_bit;
  logic             w_rom_last;

  // Pattern lookup runs on the next-cycle select/index so dout can be registered.
  seq_pattern_rom u_rom (
    .i_sel    (w_sel_nxt),
    .i_idx    (w_idx_nxt),
    .o_bit_c  (w_rom_bit),
    .o_last_c (w_rom_last)
  );

  // State, counters and registered outputs; synchronous reset discards any request.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_sel        <= SEL_101;
      r_idx        <= '0;
      r_rep        <= '0;
      r_pat_end    <= 1'b0;
      r_dout       <= 1'b0;
      r_dout_valid <= 1'b0;
      r_last       <= 1'b0;
      r_done       <= 1'b0;
`ifdef SEQ_GEN_GAP_EN
      r_gap        <= '0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_sel        <= w_sel_nxt;
      r_idx        <= w_idx_nxt;
      r_rep        <= w_rep_nxt;
      r_pat_end    <= w_dout_valid_nxt & w_rom_last;
      r_dout       <= w_dout_nxt;
      r_dout_valid <= w_dout_valid_nxt;
      r_last       <= w_last_nxt;
      r_done       <= w_done_nxt;
`ifdef SEQ_GEN_GAP_EN
      r_gap        <= w_gap_nxt;
`endif
    end
  end

  // Next-state and counter update.
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_idx_nxt   = r_idx;
    w_rep_nxt   = r_rep;
`ifdef SEQ_GEN_GAP_EN
    w_gap_nxt   = r_gap;
`endif
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_sel_nxt   = req_sel;
          w_rep_nxt   = req_count;
          w_idx_nxt   = '0;
          w_state_nxt = (req_count == '0) ? DONE : SEND;
        end
      end
      SEND: begin
        if (r_pat_end) begin
          w_idx_nxt = '0;
          if (r_rep == CNT_W'(1)) begin
            w_state_nxt = DONE;
          end else begin
            w_rep_nxt = r_rep - CNT_W'(1);
`ifdef SEQ_GEN_GAP_EN
            w_state_nxt = GAP;
            w_gap_nxt   = '0;
`else
            w_state_nxt = SEND;
`endif
          end
        end else begin
          w_idx_nxt = r_idx + IDX_W'(1);
        end
      end
`ifdef SEQ_GEN_GAP_EN
      GAP: begin
        if (r_gap == GAP_W'(GAP_LEN - 1)) begin
          w_state_nxt = SEND;
        end else begin
          w_gap_nxt = r_gap + GAP_W'(1);
        end
      end
`endif
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Next registered output values; dout and last are qualified by dout_valid.
  always_comb begin
    w_dout_valid_nxt = (w_state_nxt == SEND);
    w_dout_nxt       = w_dout_valid_nxt & w_rom_bit;
    w_last_nxt       = w_dout_valid_nxt & w_rom_last & (w_rep_nxt == CNT_W'(1));
    w_done_nxt       = (w_state_nxt == DONE);
  end

  assign req_ready  = (r_state == IDLE);
  assign busy       = (r_state != IDLE);
  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign last       = r_last;
  assign done       = r_done;

endmodule
